map_render: RTL and testbench

- Reader side of the game map interface: consumes the `map_s` structure produced by the snake movement engine and converts it into pixel colour for the VGA output path.
- Takes `hcount`/`vcount` plus sync/blank from the VGA timing block.
- Snapshots the map once per frame at vertical-blank start, so the image never tears.
- Produces 12-bit RGB through a fixed 3-cycle pipeline, with all timing signals delayed to match.

---
 rtl/map_render.sv | 189 ++++++++++++++++++
 tb/tb_map_render.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/map_render.sv
// map_render: snapshots the game map at vblank start and converts hcount/vcount into 12-bit tile colour.
// Fixed 3-cycle pipeline, one pixel per clock, no stalls; optional grid lines with MAP_RENDER_GRID_EN.
package map_pkg;
  localparam int MAP_WIDTH  = 40;
  localparam int MAP_HEIGHT = 30;

  typedef logic [1:0] tile_t;
  localparam tile_t EMPTY  = 2'd0;
  localparam tile_t SNAKE1 = 2'd1;

  typedef struct packed {
    logic [5:0]  head_x;
    logic [4:0]  head_y;
    logic [10:0] length;
    logic [1:0]  dir;
  } snake_s;

  typedef struct packed {
    tile_t [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] tiles;
    snake_s                                snake1;
  } map_s;
endpackage

module map_render
  import map_pkg::*;
#(
  parameter int TILE_SHIFT = 4,
  parameter int MAP_X0     = 0,
  parameter int MAP_Y0     = 0,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  map_s             map,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out,
  output logic             frame_latched
);
  localparam int TX_W = $clog2(MAP_WIDTH);
  localparam int TY_W = $clog2(MAP_HEIGHT);
  localparam int TI_W = CNT_W - TILE_SHIFT;
  localparam logic [TI_W-1:0]        MAP_W_T = TI_W'(MAP_WIDTH);
  localparam logic [TI_W-1:0]        MAP_H_T = TI_W'(MAP_HEIGHT);
  localparam logic signed [CNT_W:0]  X0      = (CNT_W+1)'(MAP_X0);
  localparam logic signed [CNT_W:0]  Y0      = (CNT_W+1)'(MAP_Y0);

  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             hs;
    logic             vs;
    logic             hb;
    logic             vb;
  } timing_t;

  // Snapshot: the only writer of tiles_q, and only on a vblank rising edge.
  tile_t [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] tiles_q;
  logic vblnk_prv_q, frame_q, vb_rise;

  assign vb_rise = vblnk_in & ~vblnk_prv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tiles_q     <= '0;
      vblnk_prv_q <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      vblnk_prv_q <= vblnk_in;
      frame_q     <= vb_rise;
      if (vb_rise) tiles_q <= map.tiles;
    end
  end

  // Stage 1: map-relative coordinates; the sign bit rejects pixels left/above the map.
  timing_t               tim_d, tim1_q, tim2_q, tim3_q;
  logic signed [CNT_W:0] x_rel_d, y_rel_d, x_rel_q, y_rel_q;
  logic                  in_map_d, in_map1_q, blank1_q, vld1_q;

  always_comb begin
    tim_d    = '{h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in,
                 hb: hblnk_in, vb: vblnk_in};
    x_rel_d  = $signed({1'b0, hcount_in}) - X0;
    y_rel_d  = $signed({1'b0, vcount_in}) - Y0;
    in_map_d = !x_rel_d[CNT_W] && !y_rel_d[CNT_W]
               && (x_rel_d[CNT_W-1:TILE_SHIFT] < MAP_W_T)
               && (y_rel_d[CNT_W-1:TILE_SHIFT] < MAP_H_T);
  end

  // Stage 2: tile lookup from the snapshot.
  tile_t tile_d, tile_q;
  logic  in_map2_q, blank2_q, vld2_q;

  always_comb begin
    tile_d = EMPTY;
    if (in_map1_q)
      tile_d = tiles_q[y_rel_q[TILE_SHIFT +: TY_W]][x_rel_q[TILE_SHIFT +: TX_W]];
  end

`ifdef MAP_RENDER_GRID_EN
  logic [TILE_SHIFT-1:0] x_lo_q, y_lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_lo_q <= '0;
      y_lo_q <= '0;
    end else begin
      x_lo_q <= x_rel_q[TILE_SHIFT-1:0];
      y_lo_q <= y_rel_q[TILE_SHIFT-1:0];
    end
  end
`endif

  // Stage 3: colour. vld2_q keeps the output black while the pipe refills after reset.
  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = 12'h000;
    if (vld2_q && !blank2_q) begin
      if (!in_map2_q) begin
        rgb_d = 12'h444;
      end else if (tile_q == EMPTY) begin
        rgb_d = 12'h111;
`ifdef MAP_RENDER_GRID_EN
        if (x_lo_q == '0 || y_lo_q == '0) rgb_d = 12'h333;
`endif
      end else if (tile_q == SNAKE1) begin
        rgb_d = 12'h0F0;
      end else begin
        rgb_d = 12'hF0F;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tim1_q    <= '0;
      x_rel_q   <= '0;
      y_rel_q   <= '0;
      in_map1_q <= 1'b0;
      blank1_q  <= 1'b0;
      vld1_q    <= 1'b0;
      tim2_q    <= '0;
      tile_q    <= EMPTY;
      in_map2_q <= 1'b0;
      blank2_q  <= 1'b0;
      vld2_q    <= 1'b0;
      tim3_q    <= '0;
      rgb_q     <= '0;
    end else begin
      tim1_q    <= tim_d;
      x_rel_q   <= x_rel_d;
      y_rel_q   <= y_rel_d;
      in_map1_q <= in_map_d;
      blank1_q  <= hblnk_in | vblnk_in;
      vld1_q    <= 1'b1;
      tim2_q    <= tim1_q;
      tile_q    <= tile_d;
      in_map2_q <= in_map1_q;
      blank2_q  <= blank1_q;
      vld2_q    <= vld1_q;
      tim3_q    <= tim2_q;
      rgb_q     <= rgb_d;
    end
  end

  assign hcount_out    = tim3_q.h;
  assign vcount_out    = tim3_q.v;
  assign hsync_out     = tim3_q.hs;
  assign vsync_out     = tim3_q.vs;
  assign hblnk_out     = tim3_q.hb;
  assign vblnk_out     = tim3_q.vb;
  assign rgb_out       = rgb_q;
  assign frame_latched = frame_q;

  // Snake fields and the out-of-range coordinate bits are not needed for rendering.
  logic unused_bits;
  assign unused_bits = ^{map.snake1, x_rel_q, y_rel_q};
endmodule

// File: tb/tb_map_render.sv
// Randomised bench for map_render against a frame-level reference: a per-cycle history of
// driven pixels, reset and vblank edges, with a software copy of the map snapshot.
module tb_map_render;
  import map_pkg::*;

  localparam int CNT_W = 11;
  localparam int TILE  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  map_s             map, map_nxt;
  logic [CNT_W-1:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic             hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic             hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]      rgb_out;
  logic             frame_latched;

  map_render #(.TILE_SHIFT(4), .MAP_X0(0), .MAP_Y0(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .map(map),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .frame_latched(frame_latched)
  );

  typedef struct {
    int          h;
    int          v;
    logic [3:0]  sync;   // {hs, vs, hb, vb}
    logic        rst;
    logic        pulse;
    logic [11:0] rgb;
  } hist_t;

  hist_t hist [8];
  tile_t snap [MAP_HEIGHT][MAP_WIDTH];
  logic  prv;
  int    cyc, n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  function automatic logic [11:0] ref_rgb(input int h, input int v, input logic blank);
    tile_t t;
    if (blank) return 12'h000;
    if (h >= MAP_WIDTH * TILE || v >= MAP_HEIGHT * TILE) return 12'h444;
    t = snap[v / TILE][h / TILE];
    if (t == EMPTY) begin
`ifdef MAP_RENDER_GRID_EN
      if (h % TILE == 0 || v % TILE == 0) return 12'h333;
`endif
      return 12'h111;
    end
    if (t == SNAKE1) return 12'h0F0;
    return 12'hF0F;
  endfunction

  // One clock: check outputs for the pixel driven three cycles ago, then drive the next one.
  task automatic step(input logic r, input int h, input int v,
                      input logic hs, input logic vs, input logic hb, input logic vb);
    hist_t e, n;
    logic  zero;
    @(negedge clk);
    cyc++;
    e    = hist[(cyc - 3) & 7];
    zero = e.rst | hist[(cyc - 2) & 7].rst | hist[(cyc - 1) & 7].rst;
    check("rgb",    rgb_out,    zero ? 12'h000 : e.rgb);
    check("hcount", hcount_out, zero ? 0 : e.h);
    check("vcount", vcount_out, zero ? 0 : e.v);
    check("timing", {hsync_out, vsync_out, hblnk_out, vblnk_out}, zero ? 4'h0 : e.sync);
    check("frame_latched", frame_latched, hist[(cyc - 1) & 7].pulse);

    map       = map_nxt;
    rst       = r;
    hcount_in = CNT_W'(h);
    vcount_in = CNT_W'(v);
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = {hs, vs, hb, vb};

    n.h = h; n.v = v; n.sync = {hs, vs, hb, vb}; n.rst = r;
    n.pulse = 1'b0; n.rgb = 12'h000;
    if (r) begin
      foreach (snap[i, j]) snap[i][j] = EMPTY;
      prv = 1'b1;
    end else begin
      n.pulse = vb & ~prv;
      if (n.pulse) foreach (snap[i, j]) snap[i][j] = map.tiles[i][j];
      prv   = vb;
      n.rgb = ref_rgb(h, v, hb | vb);
    end
    hist[cyc & 7] = n;
  endtask

  task automatic px(input int h, input int v);
    step(1'b0, h, v, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vblank();
    repeat (2) step(1'b0, 0, 480, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int edges [12] = '{0, 15, 16, 47, 48, 49, 463, 464, 479, 623, 639, 640};
    logic vb_state;
    n_chk = 0; n_pass = 0; cyc = 0; prv = 1'b1;
    foreach (snap[i, j]) snap[i][j] = EMPTY;
    for (int i = 0; i < MAP_HEIGHT; i++)
      for (int j = 0; j < MAP_WIDTH; j++) map_nxt.tiles[i][j] = EMPTY;
    map_nxt.snake1 = '0;
    for (int i = 0; i < 8; i++) begin
      hist[i].h = 0; hist[i].v = 0; hist[i].sync = 4'h0;
      hist[i].rst = 1'b1; hist[i].pulse = 1'b0; hist[i].rgb = 12'h000;
    end
    map = map_nxt; rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'h0;

    repeat (3) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Live map differs from the (empty) snapshot until a vblank edge arrives.
    map_nxt.tiles[2][3] = SNAKE1;
    px(56, 40); px(56, 40); px(47, 40);
    vblank();
    px(56, 40); px(47, 40); px(48, 32); px(63, 47); px(64, 40);

    // Mid-frame map edit stays invisible until the next vblank.
    map_nxt.tiles[2][3] = EMPTY;
    repeat (3) px(56, 40);
    vblank();
    px(56, 40);

    // Map edges, border and blanking with distinct sync patterns.
    map_nxt.tiles[29][39] = 2'd3;
    map_nxt.tiles[2][3]   = SNAKE1;
    vblank();
    px(639, 479); px(640, 0); px(0, 480); px(2047, 2047); px(0, 0);
    step(1'b0, 56, 40, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 57, 41, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 58, 42, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame, then reset coincident with a vblank rising edge.
    px(56, 40);
    step(1'b1, 56, 40, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) px(56, 40);
    step(1'b0, 0, 480, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 0, 480, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 0, 480, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) px(56, 40);
    vblank();
    px(56, 40);

    // Grid-line pixels around tile (3,2) in both tile states.
    px(48, 40); px(49, 41); px(48, 32); px(50, 33);
    map_nxt.tiles[2][3] = EMPTY;
    vblank();
    px(48, 40); px(49, 41); px(48, 32); px(49, 32);

    // Random map contents and scan positions with occasional vblank and reset.
    for (int i = 0; i < MAP_HEIGHT; i++)
      for (int j = 0; j < MAP_WIDTH; j++) map_nxt.tiles[i][j] = tile_t'($urandom_range(0, 3));
    vblank();
    vb_state = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int h, v, ti, tj;
      logic r;
      if ($urandom_range(0, 9) == 0) begin
        ti = $urandom_range(0, MAP_HEIGHT - 1);
        tj = $urandom_range(0, MAP_WIDTH - 1);
        map_nxt.tiles[ti][tj] = tile_t'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 39) == 0) vb_state = ~vb_state;
      h = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 11)] : $urandom_range(0, 799);
      v = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 11)] : $urandom_range(0, 524);
      r = ($urandom_range(0, 299) == 0);
      step(r, h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), vb_state);
    end
    repeat (4) px(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
